// File: rtl/mmio_pkg.sv
// mmio_pkg: shared IO offsets, FSM encoding, CTRL bit indices and byte-lane merge helper
package mmio_pkg;
  localparam logic [7:0] OFS_LED  = 8'h00;
  localparam logic [7:0] OFS_GPIO = 8'h04;
  localparam logic [7:0] OFS_TCNT = 8'h08;
  localparam logic [7:0] OFS_TCMP = 8'h0C;
  localparam logic [7:0] OFS_CTRL = 8'h10;
  localparam logic [7:0] OFS_STAT = 8'h14;
  localparam int CTRL_TEN = 0;
  localparam int CTRL_IEN = 1;
  typedef enum logic {ST_IDLE, ST_RESP} state_t;
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? wd[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/mmio_bus_unit_if.sv
// mmio_bus_unit_if: core load/store request/response bus with byte enables
interface mmio_bus_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;
  modport master(output mem_req, mem_we, mem_be, mem_addr, mem_wdata, input mem_rdata, mem_ready, mem_err);
  modport slave(input mem_req, mem_we, mem_be, mem_addr, mem_wdata, output mem_rdata, mem_ready, mem_err);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: free-running compare timer with sticky match flag and registered irq
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic        clr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic        ten,
  output logic        ien,
  output logic        match,
  output logic        irq
);
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      cnt   <= '0;
      cmp   <= '1;
      ten   <= 1'b0;
      ien   <= 1'b0;
      match <= 1'b0;
      irq   <= 1'b0;
    end else begin
      cnt <= cnt_we ? be_merge(cnt, wdata, be) : ten ? cnt + 32'd1 : cnt;
      if (cmp_we) cmp <= be_merge(cmp, wdata, be);
      if (ctrl_we && be[0]) begin
        ten <= wdata[CTRL_TEN];
        ien <= wdata[CTRL_IEN];
      end
      match <= (ten && cnt == cmp) || (match && !clr);
      irq   <= match && ien;
    end
  end
endmodule

// File: rtl/mmio_bus_unit.sv
// mmio_bus_unit: byte-addressable data RAM, LED port, synchronised GPIO and compare timer behind a req/ready bus
module mmio_bus_unit
  import mmio_pkg::*;
#(
  parameter int          RAM_BYTES = 512,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00,
  parameter int          LED_W     = 8,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  mmio_bus_unit_if.slave    bus,
  output logic [LED_W-1:0]  led,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq
);
  localparam int AW = $clog2(RAM_BYTES);
  state_t state, state_nx;
  logic [31:0] ram [RAM_BYTES/4];
  logic [GPIO_W-1:0] g1, g2;
  logic [31:0] cnt, cmp, io_rd;
  logic ten, ien, match, acc, aligned, ram_sel, io_sel, ok, io_wr;
  logic [7:0] ofs;
  logic [AW-3:0] idx;
  assign ofs     = bus.mem_addr[7:0];
  assign idx     = bus.mem_addr[AW-1:2];
  assign aligned = bus.mem_addr[1:0] == 2'b00;
  assign ram_sel = aligned && bus.mem_addr < 32'(RAM_BYTES);
  assign io_sel  = aligned && !ram_sel && bus.mem_addr[31:8] == IO_BASE[31:8];
  assign ok      = ram_sel || io_sel;
  assign acc     = state == ST_IDLE && bus.mem_req;
  assign io_wr   = acc && bus.mem_we && io_sel;
  always_ff @(posedge clk) state <= !sys_rst_n ? ST_IDLE : state_nx;
  always_comb state_nx = acc ? ST_RESP : ST_IDLE;
  always_comb bus.mem_ready = state == ST_RESP;
  always_comb begin
    io_rd = ofs == OFS_LED  ? 32'(led) :
            ofs == OFS_GPIO ? 32'(g2) :
            ofs == OFS_TCNT ? cnt :
            ofs == OFS_TCMP ? cmp :
            ofs == OFS_CTRL ? {30'b0, ien, ten} :
            ofs == OFS_STAT ? {31'b0, match} : '0;
  end
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      bus.mem_rdata <= '0;
      bus.mem_err   <= 1'b0;
      led           <= '0;
      g1            <= '0;
      g2            <= '0;
    end else begin
      g1 <= gpio_in;
      g2 <= g1;
      if (acc) begin
        bus.mem_err   <= !ok;
        bus.mem_rdata <= (!ok || bus.mem_we) ? '0 : ram_sel ? ram[idx] : io_rd;
      end
      if (io_wr && ofs == OFS_LED) led <= LED_W'(be_merge(32'(led), bus.mem_wdata, bus.mem_be));
    end
  end
  // RAM has no reset so it can map onto block memory; contents survive sys_rst_n
  always_ff @(posedge clk) begin
    if (sys_rst_n && acc && bus.mem_we && ram_sel)
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) ram[idx][8*i+:8] <= bus.mem_wdata[8*i+:8];
  end
  mmio_timer u_timer (
    .clk,
    .sys_rst_n,
    .cnt_we (io_wr && ofs == OFS_TCNT),
    .cmp_we (io_wr && ofs == OFS_TCMP),
    .ctrl_we(io_wr && ofs == OFS_CTRL),
    .clr    (io_wr && ofs == OFS_STAT && bus.mem_be[0] && bus.mem_wdata[0]),
    .be     (bus.mem_be),
    .wdata  (bus.mem_wdata),
    .cnt,
    .cmp,
    .ten,
    .ien,
    .match,
    .irq
  );
endmodule

// File: tb/tb_mmio_bus_unit.sv
// tb_mmio_bus_unit: directed checks of RAM, LED, GPIO sync, timer/irq and reset behaviour
module tb_mmio_bus_unit;
  localparam logic [31:0] IOB = 32'hFFFF_FF00;
  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [7:0] led;
  logic [7:0] gpio_in = 8'h00;
  logic irq;
  int total = 0;
  int bad = 0;
  logic [31:0] rd;
  logic er;
  mmio_bus_unit_if bus ();
  mmio_bus_unit #(.RAM_BYTES(256), .IO_BASE(IOB), .LED_W(8), .GPIO_W(8)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus), .led(led), .gpio_in(gpio_in), .irq(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rdata, output logic err);
    bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_be = be; bus.mem_addr = addr; bus.mem_wdata = wd;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.mem_ready), 32'd1);
    rdata = bus.mem_rdata;
    err = bus.mem_err;
    bus.mem_req = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_drop"}, 32'(bus.mem_ready), 32'd0);
  endtask
  initial begin
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_be = 4'h0; bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_err", 32'(bus.mem_err), 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    xfer("wr10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er);
    chk("wr10_err", 32'(er), 32'd0);
    xfer("rd10", 1'b0, 4'hF, 32'h10, 32'h0, rd, er);
    chk("rd10_data", rd, 32'hDEADBEEF);
    chk("rd10_err", 32'(er), 32'd0);
    xfer("wr10be", 1'b1, 4'b0101, 32'h10, 32'h11223344, rd, er);
    xfer("rd10be", 1'b0, 4'h0, 32'h10, 32'h0, rd, er);
    chk("rd10be_data", rd, 32'hDE22BE44);
    xfer("wrled", 1'b1, 4'hF, IOB, 32'h000000A5, rd, er);
    chk("led_a5", 32'(led), 32'hA5);
    chk("wrled_err", 32'(er), 32'd0);
    xfer("rdled", 1'b0, 4'hF, IOB, 32'h0, rd, er);
    chk("rdled_data", rd, 32'h000000A5);
    xfer("wrled_be", 1'b1, 4'b1110, IOB, 32'h0, rd, er);
    chk("led_keep", 32'(led), 32'hA5);
    xfer("wr104", 1'b1, 4'hF, 32'h104, 32'h12345678, rd, er);
    chk("wr104_err", 32'(er), 32'd1);
    xfer("rd104", 1'b0, 4'hF, 32'h104, 32'h0, rd, er);
    chk("rd104_err", 32'(er), 32'd1);
    chk("rd104_data", rd, 32'd0);
    xfer("wr12", 1'b1, 4'hF, 32'h12, 32'hFFFFFFFF, rd, er);
    chk("wr12_err", 32'(er), 32'd1);
    xfer("rd12", 1'b0, 4'hF, 32'h12, 32'h0, rd, er);
    chk("rd12_err", 32'(er), 32'd1);
    chk("rd12_data", rd, 32'd0);
    xfer("rd10keep", 1'b0, 4'hF, 32'h10, 32'h0, rd, er);
    chk("ram_unchanged", rd, 32'hDE22BE44);
    xfer("wrgpio", 1'b1, 4'hF, IOB + 32'h4, 32'hFFFFFFFF, rd, er);
    chk("wrgpio_err", 32'(er), 32'd0);
    xfer("rdunmap", 1'b0, 4'hF, IOB + 32'h40, 32'h0, rd, er);
    chk("unmap_data", rd, 32'd0);
    chk("unmap_err", 32'(er), 32'd0);
    gpio_in = 8'h5A;
    repeat (4) @(negedge clk);
    gpio_in = 8'h3C;
    @(negedge clk);
    xfer("gpio1", 1'b0, 4'hF, IOB + 32'h4, 32'h0, rd, er);
    chk("gpio_1cyc", rd, 32'h0000005A);
    gpio_in = 8'h81;
    repeat (2) @(negedge clk);
    xfer("gpio2", 1'b0, 4'hF, IOB + 32'h4, 32'h0, rd, er);
    chk("gpio_2cyc", rd, 32'h00000081);
    xfer("wrcmp", 1'b1, 4'hF, IOB + 32'hC, 32'd20, rd, er);
    xfer("wrcnt", 1'b1, 4'hF, IOB + 32'h8, 32'd0, rd, er);
    xfer("rdcnt0", 1'b0, 4'hF, IOB + 32'h8, 32'h0, rd, er);
    chk("cnt_idle", rd, 32'd0);
    xfer("wrctrl", 1'b1, 4'hF, IOB + 32'h10, 32'd3, rd, er);
    xfer("rdctrl", 1'b0, 4'hF, IOB + 32'h10, 32'h0, rd, er);
    chk("ctrl_rd", rd, 32'd3);
    for (int i = 0; i < 40 && irq !== 1'b1; i++) @(negedge clk);
    chk("irq_rise", 32'(irq), 32'd1);
    repeat (3) @(negedge clk);
    chk("irq_hold", 32'(irq), 32'd1);
    xfer("rdstat", 1'b0, 4'hF, IOB + 32'h14, 32'h0, rd, er);
    chk("stat_set", rd, 32'd1);
    xfer("clrstat", 1'b1, 4'hF, IOB + 32'h14, 32'd1, rd, er);
    chk("irq_drop", 32'(irq), 32'd0);
    xfer("rdstat2", 1'b0, 4'hF, IOB + 32'h14, 32'h0, rd, er);
    chk("stat_clr", rd, 32'd0);
    xfer("wrcntw", 1'b1, 4'hF, IOB + 32'h8, 32'hFFFFFFFE, rd, er);
    xfer("rdcntw1", 1'b0, 4'hF, IOB + 32'h8, 32'h0, rd, er);
    chk("cnt_max", rd, 32'hFFFFFFFF);
    xfer("rdcntw2", 1'b0, 4'hF, IOB + 32'h8, 32'h0, rd, er);
    chk("cnt_wrap", rd, 32'h00000001);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_be = 4'hF; bus.mem_addr = 32'h20; bus.mem_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rstw_ready", 32'(bus.mem_ready), 32'd1);
    sys_rst_n = 1'b0;
    bus.mem_req = 1'b0;
    @(negedge clk);
    chk("rstw_no_ready", 32'(bus.mem_ready), 32'd0);
    chk("rstw_led", 32'(led), 32'd0);
    chk("rstw_irq", 32'(irq), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.mem_ready), 32'd0);
    xfer("rd20", 1'b0, 4'hF, 32'h20, 32'h0, rd, er);
    chk("ram_persist", rd, 32'hCAFEF00D);
    xfer("rdcmp", 1'b0, 4'hF, IOB + 32'hC, 32'h0, rd, er);
    chk("cmp_reset", rd, 32'hFFFFFFFF);
    xfer("rdctrl2", 1'b0, 4'hF, IOB + 32'h10, 32'h0, rd, er);
    chk("ctrl_reset", rd, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_bus_unit.md
Name: mmio_bus_unit

Overview:
Parametrised memory-mapped data-side unit for the multi-cycle core: byte-addressable data RAM, LED output port, synchronised GPIO input port, and a 32-bit compare timer with interrupt. Sits between the core's load/store path and board pins, replacing the single-cycle RAM/LED unit. Adds a req/ready handshake, byte enables, error reporting and a timer.

Parameters:
RAM_BYTES, 512, data RAM size in bytes; power of two, at least 16.
IO_BASE, 32'hFFFF_FF00, base address of the 256-byte IO window.
LED_W, 8, LED output width (1..32).
GPIO_W, 8, GPIO input width (1..32).

Ports:
clk  in  1  system clock
sys_rst_n  in  1  synchronous, active-low reset
mem_req  in  1  access request, sampled in IDLE
mem_we  in  1  1 = write, 0 = read
mem_be  in  4  byte enables; be[3] = wdata[31:24] = byte at addr+0
mem_addr  in  32  byte address, word aligned
mem_wdata  in  32  write data, big-endian lanes
mem_rdata  out  32  read data, valid while mem_ready=1
mem_ready  out  1  one-cycle response pulse
mem_err  out  1  error flag, valid while mem_ready=1
led  out  LED_W  LED_OUT register
gpio_in  in  GPIO_W  asynchronous board inputs
irq  out  1  timer interrupt, level

Behaviour:
- Reset is synchronous, active-low: this block has one clock. At a clk edge with sys_rst_n=0: FSM to IDLE, mem_rdata=0, mem_ready=0, mem_err=0, led=0, irq=0, all IO registers and synchroniser flops 0. RAM contents are not reset and are undefined.
- FSM has two states.
  - IDLE: when mem_req=1, accept the request, commit any write at this edge, register the response, go to RESP.
  - RESP: mem_ready=1 for exactly one cycle, then IDLE. mem_req in RESP is ignored.
  - Throughput is at most one access per 2 cycles. Latency is request edge to ready in 1 cycle.
- Decode:
  - RAM hit: addr < RAM_BYTES.
  - IO hit: addr[31:8] == IO_BASE[31:8].
  - Anything else, or addr[1:0] != 0: mem_err=1, mem_rdata=0, write dropped.
- RAM write: only the bytes with be=1 are written. Reads return the full word and ignore be.
- IO registers, by offset; bytes with be=0 are preserved:
  - 0x00 LED_OUT: RW, low LED_W bits, upper bits read 0.
  - 0x04 GPIO_IN: RO, 2-flop synchronised gpio_in, zero-extended. Writes are ignored with no error.
  - 0x08 TIMER_CNT: RW. A write loads the count.
  - 0x0C TIMER_CMP: RW, reset 32'hFFFF_FFFF.
  - 0x10 CTRL: bit0 = timer enable, bit1 = irq enable. Other bits read 0.
  - 0x14 STATUS: bit0 = match flag. Writing 1 clears it.
  - Other IO offsets read 0 with mem_err=0.
- Timer:
  - When enabled, the count increments every cycle and wraps from 32'hFFFF_FFFF to 0.
  - When enabled and cnt == cmp, the match flag is set and stays set (sticky). irq = match & irq_en, registered.
  - If a TIMER_CNT write and an increment fall in the same cycle, the write wins.
  - If a STATUS clear and a new match fall in the same cycle, the set wins.
- Reset mid-operation: a write committed before reset persists in RAM. A pending RESP is discarded, and mem_ready=0 after the reset edge.
- Read data for an IO register reflects its value before any same-edge update.

Decomposition:
- Package mmio_pkg holds:
  - IO offset constants (OFS_LED, OFS_GPIO, OFS_TCNT, OFS_TCMP, OFS_CTRL, OFS_STAT);
  - FSM state encoding (ST_IDLE, ST_RESP);
  - CTRL bit indices.
- One sub-module, mmio_timer, holds the counter, compare, match flag and irq. Its inputs are the write strobes, byte enables, wdata and clear.
- RAM byte-lane logic and decode stay in the top level.

Test Plan:
- Write 0xDEADBEEF, be=4'hF, to 0x10, then read 0x10 -> ready 1 cycle after each request, rdata=0xDEADBEEF, err=0.
- Write 0x11223344 with be=4'b0101 over 0xDEADBEEF at 0x10, then read -> rdata=0xDE22BE44.
- Write 0x000000A5 to IO_BASE+0x00 -> led=8'hA5 after the accept edge. Read 0x104 (out of range) and 0x12 (misaligned) -> err=1, rdata=0, RAM unchanged.
- Drive gpio_in=8'h3C, wait 2 cycles, read IO_BASE+0x04 -> 0x0000003C. Read at 1 cycle -> previous value.
- Set CMP=20, CNT=0, then CTRL=3 -> irq rises within 22 cycles and stays high. Write STATUS=1 -> irq drops. The count wraps at 0xFFFFFFFF after a load of 0xFFFFFFFE.
- Assert sys_rst_n=0 during RESP of a write to 0x20 -> no ready pulse after reset and led=0. After reset, a read of 0x20 returns the written value.
